rng_mem_writer: RTL and testbench

Avalon-MM write-only master that draws 4-digit decimal random numbers from a 16-bit Galois LFSR and logs them as 32-bit words into the single-port on-chip RAM (1024 x 32, byte-enabled, no waitrequest). Sits directly upstream of the on-chip memory slave s1. It converts each accepted draw to packed BCD and keeps a circular write pointer across runs. It also exposes the latest value for the 7-segment display path.

---
 rtl/rng_mem_writer.sv | 112 +++++++++++
 tb/tb_rng_mem_writer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rng_mem_writer.sv
// Avalon-MM write master: draws decimal 0..9999 values from a Galois LFSR,
// converts them to BCD by serial double-dabble and logs {bin, bcd} words to on-chip RAM.
module rng_mem_writer #(
    parameter int          DEPTH  = 1024,
    parameter int          ADDR_W = 10,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [10:0]       count,
    output logic              busy,
    output logic              done,
    output logic [15:0]       last_bcd,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write,
    output logic [3:0]        byteenable,
    output logic [31:0]       writedata,
    output logic              clken
);
    typedef enum logic [2:0] {S_IDLE, S_DRAW, S_CONV, S_WRITE, S_DONE} state_t;

    state_t      state, state_n;
    logic [15:0] lfsr, lfsr_step;
    logic [13:0] cand, bin_r, sh;
    logic [15:0] bcd, bcd_adj;
    logic [3:0]  bit_cnt;
    logic [10:0] remaining;
    logic        accept;

    assign clken     = 1'b1;
    assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign cand      = lfsr_step[13:0];
    assign accept    = cand < 14'd10000;

    // add-3 on any digit >= 5 before each shift keeps the digits decimal
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < 4; d++)
            if (bcd[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = (count == 11'd0) ? S_DONE : S_DRAW;
            S_DRAW:  if (accept) state_n = S_CONV;
            S_CONV:  if (bit_cnt == 4'd13) state_n = S_WRITE;
            S_WRITE: state_n = (remaining == 11'd1) ? S_DONE : S_DRAW;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            lfsr       <= SEED;
            wr_ptr     <= '0;
            remaining  <= '0;
            bin_r      <= '0;
            sh         <= '0;
            bcd        <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            last_bcd   <= '0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            byteenable <= '0;
            address    <= '0;
            writedata  <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: if (start) remaining <= (count > 11'(DEPTH)) ? 11'(DEPTH) : count;
                S_DRAW: begin
                    lfsr <= lfsr_step;
                    if (accept) begin
                        bin_r   <= cand;
                        sh      <= cand;
                        bcd     <= '0;
                        bit_cnt <= '0;
                    end
                end
                S_CONV: begin
                    sh      <= {sh[12:0], 1'b0};
                    bcd     <= {bcd_adj[14:0], sh[13]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                S_WRITE: begin
                    wr_ptr    <= (wr_ptr == ADDR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
                    remaining <= remaining - 11'd1;
                    last_bcd  <= bcd;
                end
                default: ;
            endcase
            // bus and status outputs trail the state by one registered cycle
            busy       <= (state == S_DRAW) || (state == S_CONV) || (state == S_WRITE);
            done       <= (state == S_DONE);
            chipselect <= (state == S_WRITE);
            write      <= (state == S_WRITE);
            byteenable <= (state == S_WRITE) ? 4'hF : 4'h0;
            if (state == S_WRITE) begin
                address   <= wr_ptr;
                writedata <= {2'b00, bin_r, bcd};
            end
        end
    end
endmodule

// File: tb/tb_rng_mem_writer.sv
// Directed bench for rng_mem_writer: LFSR/decimal reference model, RAM model, timing checks.
module tb_rng_mem_writer;
    logic        clk = 0, reset_n = 0, start = 0;
    logic [10:0] count = 0;
    logic        busy, done, chipselect, write, clken;
    logic [15:0] last_bcd;
    logic [9:0]  wr_ptr, address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;

    rng_mem_writer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .count(count),
        .busy(busy), .done(done), .last_bcd(last_bcd), .wr_ptr(wr_ptr),
        .address(address), .chipselect(chipselect), .write(write),
        .byteenable(byteenable), .writedata(writedata), .clken(clken)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [1024];
    always @(posedge clk)
        if (chipselect && write)
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) mem[address][b*8 +: 8] <= writedata[b*8 +: 8];

    logic [9:0]  w_addr [$];
    logic [31:0] w_data [$];
    int          w_cyc  [$];
    logic        busy_seen = 0, cs_seen = 0;
    always @(negedge clk) begin
        if (chipselect && write) begin
            w_addr.push_back(address);
            w_data.push_back(writedata);
            w_cyc.push_back(cyc);
        end
        if (busy) busy_seen <= 1;
        if (chipselect) cs_seen <= 1;
    end

    logic [15:0] m_lfsr = 16'hACE1;
    logic [31:0] e_data [$];
    int          e_cyc  [$];
    int          kcyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic next_word(output logic [31:0] w, output int rej);
        int v;
        logic [15:0] bcd;
        rej = 0;
        forever begin
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            if (m_lfsr[13:0] < 14'd10000) break;
            rej++;
        end
        v = int'(m_lfsr[13:0]);
        bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
        w = {2'b00, m_lfsr[13:0], bcd};
    endtask

    task automatic clear_obs();
        w_addr.delete(); w_data.delete(); w_cyc.delete();
        e_data.delete(); e_cyc.delete();
        busy_seen = 0; cs_seen = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset_n = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        m_lfsr = 16'hACE1;
        clear_obs();
    endtask

    // start sampled at edge k; kcyc is the cycle number seen just after edge k
    task automatic do_start(input int cnt, input int nexp);
        logic [31:0] w;
        int rej, t;
        @(negedge clk); start = 1; count = 11'(cnt);
        @(posedge clk);
        @(negedge clk); start = 0; kcyc = cyc;
        t = kcyc;
        for (int i = 0; i < nexp; i++) begin
            next_word(w, rej);
            t += 16 + rej;
            e_data.push_back(w);
            e_cyc.push_back(t);
        end
    endtask

    task automatic wait_done(input int maxc, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done) begin dcyc = cyc; break; end
        end
        if (dcyc < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int dc, bad_a, bad_d, bad_fmt, n1;
        logic [31:0] d;

        // reset state
        do_reset();
        chk("rst_status", {busy, done, chipselect, write, clken}, 5'b00001);
        chk("rst_bus", {byteenable, address, 18'h0}, 32'h0);
        chk("rst_wdata", writedata, 32'h0);
        chk("rst_ptr_bcd", {wr_ptr, last_bcd}, 26'h0);

        // single word right after reset
        do_start(1, 1);
        @(negedge clk);
        chk("t1_busy_k1", busy, 1);
        wait_done(100, dc);
        chk("t1_nwrites", w_addr.size(), 1);
        if (w_addr.size() == 1) begin
            chk("t1_addr", w_addr[0], 0);
            chk("t1_data", w_data[0], 32'h22708816);
            chk("t1_wcyc", w_cyc[0], kcyc + 16);
        end
        chk("t1_done_cyc", dc, kcyc + 17);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_last_bcd", last_bcd, 16'h8816);
        chk("t1_wr_ptr", wr_ptr, 1);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);

        // three back-to-back words with exact timing incl. rejections
        do_reset();
        do_start(3, 3);
        wait_done(200, dc);
        chk("t2_nwrites", w_addr.size(), 3);
        bad_fmt = 0;
        for (int i = 0; i < 3 && i < w_addr.size(); i++) begin
            chk($sformatf("t2_addr%0d", i), w_addr[i], i);
            chk($sformatf("t2_data%0d", i), w_data[i], e_data[i]);
            chk($sformatf("t2_cyc%0d", i), w_cyc[i], e_cyc[i]);
            d = w_data[i];
            if (d[29:16] >= 14'd10000 || d[15:12] > 9 || d[11:8] > 9 || d[7:4] > 9 || d[3:0] > 9)
                bad_fmt++;
        end
        chk("t2_fmt", bad_fmt, 0);
        chk("t2_done_cyc", dc, e_cyc[2] + 1);
        chk("t2_last_bcd", last_bcd, e_data[2][15:0]);

        // zero count
        clear_obs();
        do_start(0, 0);
        wait_done(5, dc);
        chk("t4_zero_done", dc, kcyc + 1);
        chk("t4_zero_quiet", {busy_seen, cs_seen}, 2'b00);

        // start while busy is dropped
        n1 = w_addr.size();
        do_start(2, 2);
        repeat (10) @(negedge clk);
        start = 1; count = 11'd5;
        @(negedge clk); start = 0;
        wait_done(200, dc);
        chk("t4_ignored_start", w_addr.size() - n1, 2);
        chk("t4_ptr", wr_ptr, 5);
        repeat (40) @(negedge clk);
        chk("t4_no_extra", w_addr.size() - n1, 2);

        // full memory then wrap
        do_reset();
        do_start(1024, 1024);
        wait_done(20000, dc);
        chk("t3_nwrites", w_addr.size(), 1024);
        bad_a = 0; bad_d = 0;
        for (int i = 0; i < w_addr.size() && i < 1024; i++) begin
            if (w_addr[i] != 10'(i)) bad_a++;
            if (w_data[i] != e_data[i]) bad_d++;
        end
        chk("t3_addr_err", bad_a, 0);
        chk("t3_data_err", bad_d, 0);
        chk("t3_ptr_wrapped", wr_ptr, 0);
        clear_obs();
        do_start(2, 2);
        wait_done(200, dc);
        chk("t3_wrap_n", w_addr.size(), 2);
        if (w_addr.size() == 2) begin
            chk("t3_wrap_a0", w_addr[0], 0);
            chk("t3_wrap_a1", w_addr[1], 1);
            chk("t3_wrap_d1", w_data[1], e_data[1]);
        end
        chk("t3_ram0", mem[0], e_data[0]);

        // reset during CONV of word 2, with start held alongside reset
        do_reset();
        do_start(5, 0);
        for (int i = 0; i < 200 && w_addr.size() == 0; i++) @(negedge clk);
        chk("t5_first", w_addr.size(), 1);
        repeat (6) @(negedge clk);
        reset_n = 0; start = 1; count = 11'd3;
        @(negedge clk);
        chk("t5_write_drop", {write, chipselect, busy}, 3'b000);
        reset_n = 1; start = 0;
        busy_seen = 0; m_lfsr = 16'hACE1;
        repeat (40) @(negedge clk);
        chk("t5_no_write", w_addr.size(), 1);
        chk("t5_no_busy", busy_seen, 0);
        chk("t5_ptr", wr_ptr, 0);
        clear_obs();
        do_start(1, 1);
        wait_done(100, dc);
        chk("t5_rerun_n", w_addr.size(), 1);
        if (w_addr.size() == 1) chk("t5_rerun_data", w_data[0], 32'h22708816);

        // count above DEPTH saturates
        do_reset();
        do_start(1100, 0);
        wait_done(20000, dc);
        chk("t6_sat_n", w_addr.size(), 1024);
        chk("t6_sat_ptr", wr_ptr, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
